// File: rtl/witf_scoreboard_pkg.sv
// Shared constants for the write-in-flight table. The defaults match the decode-stage
// register file: a 4-entry table and 5-bit register addresses.
package witf_scoreboard_pkg;

  localparam int unsigned WITF_DEPTH = 4;
  localparam int unsigned REG_ADDR_W = 5;

endpackage : witf_scoreboard_pkg

// File: rtl/witf_scoreboard_match.sv
// Hazard compare for decode. Raises is_raw when rs1 or rs2 names the destination of any
// valid in-flight entry. Register x0 never counts as a hazard.
module witf_scoreboard_match
  import witf_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = WITF_DEPTH,
  parameter int unsigned AW    = REG_ADDR_W
) (
  input  logic [AW-1:0]             rs1,
  input  logic [AW-1:0]             rs2,
  input  logic [DEPTH-1:0]          valid,
  input  logic [DEPTH-1:0][AW-1:0]  ent,
  output logic                      is_raw
);

  logic rs1_nz_s;
  logic rs2_nz_s;

  assign rs1_nz_s = (rs1 != '0);
  assign rs2_nz_s = (rs2 != '0);

  // OR-reduce the per-entry matches over the valid mask
  always_comb begin
    is_raw = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && ((rs1_nz_s && (rs1 == ent[i])) || (rs2_nz_s && (rs2 == ent[i])))) begin
        is_raw = 1'b1;
      end else begin
        is_raw = is_raw;
      end
    end
  end

endmodule : witf_scoreboard_match

// File: rtl/witf_scoreboard.sv
// Write-in-flight table: an in-order FIFO of outstanding register-file destinations.
// It drives the decode stall (isRAW) and the full/empty/error status back to decode.
module witf_scoreboard
  import witf_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = WITF_DEPTH,
  parameter int unsigned AW    = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          push,
  input  logic          push_wen,
  input  logic [AW-1:0] push_rd,
  input  logic          pop,
  input  logic          pop_wen,
  input  logic [AW-1:0] pop_rd,
  input  logic          flush,
  output logic          isRAW,
  output logic          witf_full,
  output logic          witf_empty,
  output logic          witf_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] mem_q;
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     err_q, err_d;

  logic             alloc_s, rel_s, do_alloc_s, do_rel_s, wr_en_s;
  logic             full_s, empty_s;
  logic             drop_err_s, empty_err_s, mism_err_s;
  logic [DEPTH-1:0] valid_s;
  logic [PW-1:0]    off_s;

  assign alloc_s = push & push_wen & (push_rd != '0);
  assign rel_s   = pop & pop_wen & (pop_rd != '0);
  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == '0);

  // A release at full frees a slot on the same edge, so a paired alloc is still accepted
  assign do_rel_s   = rel_s & ~empty_s;
  assign do_alloc_s = alloc_s & (~full_s | do_rel_s);

  assign drop_err_s  = alloc_s & full_s & ~do_rel_s;
  assign empty_err_s = rel_s & empty_s;
  assign mism_err_s  = do_rel_s & (pop_rd != mem_q[head_q]);

  // Entry i is live when its distance from head is below the occupancy count
  always_comb begin
    valid_s = '0;
    off_s   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off_s      = PW'(i) - head_q;
      valid_s[i] = ({1'b0, off_s} < count_q);
    end
  end

  // Next-state for pointers, occupancy and the sticky error; flush discards this cycle's alloc/rel
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en_s = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      err_d   = err_q | drop_err_s | empty_err_s | mism_err_s;
      wr_en_s = do_alloc_s;
      if (do_rel_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (do_alloc_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      case ({do_alloc_s, do_rel_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Destination storage, written at tail on an accepted allocation
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_en_s) begin
      mem_q[tail_q] <= push_rd;
    end else begin
      mem_q <= mem_q;
    end
  end

  witf_scoreboard_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_witf_match (
    .rs1    (rs1),
    .rs2    (rs2),
    .valid  (valid_s),
    .ent    (mem_q),
    .is_raw (isRAW)
  );

  assign witf_full  = full_s;
  assign witf_empty = empty_s;
  assign witf_err   = err_q;

endmodule : witf_scoreboard

// File: tb/tb_witf_scoreboard.sv
// Scoreboard bench for witf_scoreboard: a queue-based reference model predicts every cycle's
// outputs, and a separate monitor compares them against the DUT after inputs settle.
module tb_witf_scoreboard;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, push, push_wen, pop, pop_wen, flush;
  logic [4:0] rs1, rs2, push_rd, pop_rd;
  logic       isRAW, witf_full, witf_empty, witf_err;

  typedef struct {
    logic raw;
    logic full;
    logic empty;
    logic err;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   model_q[$];
  logic m_err;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  always #5 clk = ~clk;

  witf_scoreboard dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .push(push), .push_wen(push_wen), .push_rd(push_rd),
    .pop(pop), .pop_wen(pop_wen), .pop_rd(pop_rd), .flush(flush),
    .isRAW(isRAW), .witf_full(witf_full), .witf_empty(witf_empty), .witf_err(witf_err)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0b expected=%0b", nm, cycle, act, exp);
    end
  endtask

  // One clock of stimulus: predict outputs from the model, queue them, then advance the model.
  task automatic cyc(input logic r, input logic fl,
                     input logic ps, input logic pw, input logic [4:0] prd,
                     input logic pp, input logic ppw, input logic [4:0] pprd,
                     input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    bit   al, rl;
    int   n;
    @(negedge clk);
    cycle++;
    rst = r; flush = fl; push = ps; push_wen = pw; push_rd = prd;
    pop = pp; pop_wen = ppw; pop_rd = pprd; rs1 = a; rs2 = b;
    if (!r) begin
      e.raw = 1'b0;
      foreach (model_q[i]) begin
        if ((a != 0 && int'(a) == model_q[i]) || (b != 0 && int'(b) == model_q[i])) e.raw = 1'b1;
      end
      e.full  = (model_q.size() == DEPTH);
      e.empty = (model_q.size() == 0);
      e.err   = m_err;
      e.cyc   = cycle;
      exp_q.push_back(e);
    end
    if (r) begin
      model_q.delete();
      m_err = 1'b0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      al = ps && pw && (prd != 0);
      rl = pp && ppw && (pprd != 0);
      n  = model_q.size();
      if (rl) begin
        if (n == 0) m_err = 1'b1;
        else begin
          if (model_q[0] != int'(pprd)) m_err = 1'b1;
          void'(model_q.pop_front());
        end
      end
      if (al) begin
        if (n == DEPTH && !(rl && n > 0)) m_err = 1'b1;
        else model_q.push_back(int'(prd));
      end
    end
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, a, b);
  endtask
  task automatic alloc(input logic [4:0] rd);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, rd, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic rel(input logic [4:0] rd, input logic [4:0] a);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, rd, a, 5'd0);
  endtask
  task automatic reset1();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Monitor: outputs are always presented, so pop one prediction per settled cycle
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("isRAW", isRAW, e.raw);
      chk("witf_full", witf_full, e.full);
      chk("witf_empty", witf_empty, e.empty);
      chk("witf_err", witf_err, e.err);
    end
  end

  initial begin
    logic [4:0] hd;
    m_err = 1'b0;
    rst = 1'b1; flush = 1'b0; push = 1'b0; push_wen = 1'b0; push_rd = 5'd0;
    pop = 1'b0; pop_wen = 1'b0; pop_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

    reset1();
    idle(5'd0, 5'd0); #3;
    chk("rst_empty", witf_empty, 1'b1);
    chk("rst_err", witf_err, 1'b0);

    alloc(5'd5);
    idle(5'd5, 5'd0); #3; chk("raw_rs1", isRAW, 1'b1);
    idle(5'd0, 5'd5); #3; chk("raw_rs2", isRAW, 1'b1);
    idle(5'd6, 5'd6); #3; chk("raw_miss", isRAW, 1'b0);
    rel(5'd5, 5'd5);  #3; chk("raw_rel_cycle", isRAW, 1'b1);
    idle(5'd5, 5'd0); #3; chk("raw_after_rel", isRAW, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0); #3;
    chk("x0_empty", witf_empty, 1'b1);
    chk("x0_raw", isRAW, 1'b0);

    for (int i = 1; i <= 4; i++) alloc(5'(i));
    idle(5'd0, 5'd0); #3; chk("fill_full", witf_full, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0);
    idle(5'd1, 5'd0); #3;
    chk("wrap_full", witf_full, 1'b1);
    chk("wrap_freed", isRAW, 1'b0);
    rel(5'd2, 5'd0); rel(5'd3, 5'd0); rel(5'd4, 5'd0); rel(5'd7, 5'd0);
    idle(5'd7, 5'd0); #3;
    chk("drain_empty", witf_empty, 1'b1);
    chk("drain_err", witf_err, 1'b0);

    for (int i = 1; i <= 5; i++) alloc(5'(i));
    idle(5'd5, 5'd0); #3;
    chk("drop_err", witf_err, 1'b1);
    chk("drop_raw", isRAW, 1'b0);
    reset1();
    rel(5'd3, 5'd0);
    idle(5'd0, 5'd0); #3; chk("rel_empty_err", witf_err, 1'b1);
    flush = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0); #3; chk("err_sticky_flush", witf_err, 1'b1);
    reset1();
    alloc(5'd3);
    rel(5'd9, 5'd0);
    idle(5'd3, 5'd0); #3;
    chk("mism_err", witf_err, 1'b1);
    chk("mism_freed", witf_empty, 1'b1);

    reset1();
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd8, 5'd0); #3;
    chk("flush_raw", isRAW, 1'b0);
    chk("flush_empty", witf_empty, 1'b1);

    reset1();
    for (int n = 0; n < 10000; n++) begin
      hd = (model_q.size() > 0 && $urandom_range(99) < 85) ? 5'(model_q[0]) : 5'($urandom_range(7));
      cyc($urandom_range(999) < 5, $urandom_range(99) < 3,
          $urandom_range(99) < 60, $urandom_range(99) < 85, 5'($urandom_range(7)),
          $urandom_range(99) < 50, $urandom_range(99) < 85, hd,
          5'($urandom_range(7)), 5'($urandom_range(7)));
    end
    idle(5'd0, 5'd0);
    @(negedge clk); #4;
    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_witf_scoreboard
